ram_arbiter: RTL and testbench

Two-port controller in front of the 64 KiB byte-addressed unified RAM. It serialises instruction fetches and data loads/stores onto the single RAM port, sequences each access through the RAM's one-cycle registered read, and performs read-modify-write for byte/halfword stores, which the word-wide RAM cannot do natively. It sits between the CPU core's fetch and load/store units and the RAM.

---
 rtl/ram_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_ram_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//
// Two-port controller in front of the 64 KiB byte-addressed unified RAM.
// Instruction fetches and data loads/stores share the single RAM port.
// Each access goes through the RAM's one-cycle registered read. Byte and
// halfword stores become a read-modify-write, because the RAM only writes
// whole words.
//
// Ports
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   i_req/i_addr    instruction read request and byte address
//   i_ack/i_rdata   one-cycle completion pulse and fetched word
//   d_req/d_we      data request; 1 = store, 0 = load
//   d_size          00 byte, 01 half, 10/11 word
//   d_signed        sign-extend sub-word loads
//   d_addr/d_wdata  data byte address and store data (low bytes used)
//   d_ack/d_rdata   one-cycle completion pulse and extended load data
//   ram_addr        registered RAM address
//   ram_wdata       registered RAM write data
//   ram_wen         registered RAM write enable
//   ram_rdata       RAM registered read data
//
// Configuration
//   RAM_ARB_RR_EN   when defined, round-robin arbitration between the ports
//                   (the port not granted most recently wins a tie). When
//                   undefined, data always beats instruction and no
//                   last-grant register exists.

module ram_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_signed,
   input  logic [15:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [15:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_wen,
   input  logic [31:0] ram_rdata
);

   typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

   state_t      state_q, state_d;
   // Granted port of the access in flight: 1 = data, 0 = instruction.
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [15:0] ram_addr_q, ram_addr_d;
   logic [31:0] ram_wdata_q, ram_wdata_d;
   logic        ram_wen_q, ram_wen_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic        sel_data;
   logic [31:0] load_ext;
   logic [31:0] rmw_merge;

`ifdef RAM_ARB_RR_EN
   // Port granted most recently: 1 = data, 0 = instruction.
   logic        last_grant_q, last_grant_d;
`endif

   // Arbitration: which port wins if IDLE grants this cycle.
   always_comb begin
`ifdef RAM_ARB_RR_EN
      if (i_req && d_req) begin
         sel_data = ~last_grant_q;
      end else begin
         sel_data = d_req;
      end
`else
      sel_data = d_req;
`endif
   end

   // Load extension and sub-word merge, both taken from the word the RAM
   // returns in RDW. During an RMW, ram_wdata_q still holds the store
   // operand latched at grant time. The RAM ignores it until the write
   // cycle, so that register doubles as the operand latch.
   always_comb begin
      case (size_q)
         2'b00:   load_ext = {{24{signed_q & ram_rdata[7]}},  ram_rdata[7:0]};
         2'b01:   load_ext = {{16{signed_q & ram_rdata[15]}}, ram_rdata[15:0]};
         default: load_ext = ram_rdata;
      endcase
      if (size_q == 2'b00) begin
         rmw_merge = {ram_rdata[31:8], ram_wdata_q[7:0]};
      end else begin
         rmw_merge = {ram_rdata[31:16], ram_wdata_q[15:0]};
      end
   end

   // Next-state and output logic. Write enable and acks default low, so
   // each is a single-cycle pulse in WR and DONE respectively.
   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      we_d        = we_q;
      size_d      = size_q;
      signed_d    = signed_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_wen_d   = 1'b0;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef RAM_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif

      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               port_d = sel_data;
`ifdef RAM_ARB_RR_EN
               last_grant_d = sel_data;
`endif
               if (sel_data) begin
                  ram_addr_d  = d_addr;
                  ram_wdata_d = d_wdata;
                  we_d        = d_we;
                  size_d      = d_size;
                  signed_d    = d_signed;
                  // Only a full-word store can skip the read.
                  if (d_we && d_size[1]) begin
                     ram_wen_d = 1'b1;
                     state_d   = WR;
                  end else begin
                     state_d   = RD;
                  end
               end else begin
                  ram_addr_d = i_addr;
                  we_d       = 1'b0;
                  size_d     = 2'b10;
                  signed_d   = 1'b0;
                  state_d    = RD;
               end
            end
         end

         RD: begin
            state_d = RDW;
         end

         RDW: begin
            if (we_q) begin
               ram_wdata_d = rmw_merge;
               ram_wen_d   = 1'b1;
               state_d     = WR;
            end else begin
               if (port_q) begin
                  d_rdata_d = load_ext;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = ram_rdata;
                  i_ack_d   = 1'b1;
               end
               state_d = DONE;
            end
         end

         WR: begin
            // Only the data port ever writes.
            d_ack_d = 1'b1;
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset clears ram_wen immediately, so an
   // access aborted before its write edge leaves memory unmodified.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         port_q      <= 1'b0;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         ram_addr_q  <= 16'h0000;
         ram_wdata_q <= 32'h0000_0000;
         ram_wen_q   <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= 32'h0000_0000;
         d_rdata_q   <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         we_q        <= we_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wen_q   <= ram_wen_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

`ifdef RAM_ARB_RR_EN
   // Last-grant register. It resets to instruction, so the first contention
   // after reset goes to the data port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`endif

   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_wen   = ram_wen_q;
   assign i_ack     = i_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter.
//
// A byte-array RAM model with one-cycle registered read sits behind the
// arbiter. The reference model keeps its own byte-array image of memory.
// For every batch of requests, it works out the grant order from the
// arbitration rule. It then applies each access to its image in that order
// and queues the expected responses.
//
// A monitor process pops those expectations whenever an ack appears. The
// driver checks latency and the number of RAM write pulses per batch.

module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_signed;
   logic [15:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [15:0] ram_addr;
   logic [31:0] ram_wdata;
   logic        ram_wen;
   logic [31:0] ram_rdata;

   // Backdoor preload into the RAM model.
   logic        pl_en;
   logic [15:0] pl_addr;
   logic [31:0] pl_data;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [15:0] addr;
      logic [31:0] wdata;
   } txn_t;

   txn_t        i_txns[$];
   txn_t        d_txns[$];
   logic        exp_order[$];
   logic [31:0] exp_i_data[$];
   logic [32:0] exp_d_data[$];

   logic [7:0]  ram_mem [0:65535];
   logic [7:0]  ref_mem [0:65535];
   bit          mem_init = 1'b0;
   logic        model_last;
   int          checks;
   int          fails;
   int          wen_count;

   ram_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_size    (d_size),
      .d_signed  (d_signed),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_wen   (ram_wen),
      .ram_rdata (ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fill_byte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // RAM model: little-endian unaligned words, 16-bit wrap, and a
   // one-cycle registered read.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int k = 0; k < 65536; k++) ram_mem[k] = fill_byte(16'(k));
         mem_init = 1'b1;
      end
      if (pl_en) begin
         for (int k = 0; k < 4; k++) ram_mem[pl_addr + 16'(k)] = pl_data[8*k +: 8];
      end
      if (ram_wen) begin
         for (int k = 0; k < 4; k++) ram_mem[ram_addr + 16'(k)] = ram_wdata[8*k +: 8];
      end
      ram_rdata <= {ram_mem[ram_addr + 16'd3], ram_mem[ram_addr + 16'd2],
                    ram_mem[ram_addr + 16'd1], ram_mem[ram_addr]};
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic txn_t mk_txn(input logic we, input logic [1:0] size, input logic sgn,
                                   input logic [15:0] addr, input logic [31:0] wdata);
      txn_t t;
      t.we    = we;
      t.size  = size;
      t.sgn   = sgn;
      t.addr  = addr;
      t.wdata = wdata;
      return t;
   endfunction

   function automatic txn_t rand_txn(input logic data_port);
      txn_t t;
      if ($urandom_range(0, 5) == 0) t.addr = 16'($urandom_range(16'hFFFC, 16'hFFFF));
      else                           t.addr = 16'(16'h3000 + $urandom_range(0, 31));
      if (data_port) begin
         t.we    = 1'($urandom_range(0, 1));
         t.size  = 2'($urandom_range(0, 3));
         t.sgn   = 1'($urandom_range(0, 1));
         t.wdata = $urandom();
      end else begin
         t.we    = 1'b0;
         t.size  = 2'b10;
         t.sgn   = 1'b0;
         t.wdata = 32'h0;
      end
      return t;
   endfunction

   function automatic logic [31:0] ref_word(input logic [15:0] a);
      return {ref_mem[a + 16'd3], ref_mem[a + 16'd2], ref_mem[a + 16'd1], ref_mem[a]};
   endfunction

   // Reference access on the model memory: stores write 1, 2 or 4 bytes;
   // loads return the word, optionally narrowed and extended.
   function automatic logic [31:0] ref_access(input txn_t t, input logic data_port);
      logic [31:0] w;
      int          nbytes;
      w = ref_word(t.addr);
      if (data_port && t.we) begin
         nbytes = (t.size == 2'b00) ? 1 : (t.size == 2'b01) ? 2 : 4;
         for (int k = 0; k < nbytes; k++) ref_mem[t.addr + 16'(k)] = t.wdata[8*k +: 8];
         return 32'h0;
      end
      if (!data_port) return w;
      case (t.size)
         2'b00:   return {{24{t.sgn & w[7]}},  w[7:0]};
         2'b01:   return {{16{t.sgn & w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Decide the grant order for the pending batch and queue expectations.
   task automatic plan_run();
      int ni = i_txns.size();
      int nd = d_txns.size();
      int xi = 0;
      int xd = 0;
      logic [31:0] r;
      while (xi < ni || xd < nd) begin
         logic pick_d;
         if (xi < ni && xd < nd) begin
`ifdef RAM_ARB_RR_EN
            pick_d = (model_last == 1'b0);
`else
            pick_d = 1'b1;
`endif
         end else begin
            pick_d = (xd < nd);
         end
         model_last = pick_d;
         exp_order.push_back(pick_d);
         if (pick_d) begin
            r = ref_access(d_txns[xd], 1'b1);
            exp_d_data.push_back({~d_txns[xd].we, r});
            xd++;
         end else begin
            r = ref_access(i_txns[xi], 1'b0);
            exp_i_data.push_back(r);
            xi++;
         end
      end
   endtask

   task automatic drive_i(input txn_t t);
      i_req  = 1'b1;
      i_addr = t.addr;
   endtask

   task automatic drive_d(input txn_t t);
      d_req    = 1'b1;
      d_we     = t.we;
      d_size   = t.size;
      d_signed = t.sgn;
      d_addr   = t.addr;
      d_wdata  = t.wdata;
   endtask

   task automatic preload(input logic [15:0] a, input logic [31:0] w);
      for (int k = 0; k < 4; k++) ref_mem[a + 16'(k)] = w[8*k +: 8];
      @(negedge clk);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = w;
      @(negedge clk);
      pl_en   = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst   = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      model_last = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Issue every queued transaction on both ports, each port holding its
   // request until its ack and moving straight to its next operation.
   task automatic applyStimulus(input string name);
      int cyc       = 0;
      int wen_exp   = 0;
      int lat_exp   = 0;
      int wen_start;
      bit single;
      single = (i_txns.size() + d_txns.size()) == 1;
      foreach (d_txns[k]) if (d_txns[k].we) wen_exp++;
      if (i_txns.size() == 1) lat_exp = 3;
      else if (d_txns.size() == 1) lat_exp = !d_txns[0].we ? 3 : (d_txns[0].size[1] ? 2 : 4);
      plan_run();
      @(negedge clk);
      wen_start = wen_count;
      if (i_txns.size() > 0) drive_i(i_txns[0]);
      if (d_txns.size() > 0) drive_d(d_txns[0]);
      while ((i_txns.size() > 0 || d_txns.size() > 0) && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (i_ack && i_txns.size() > 0) begin
            void'(i_txns.pop_front());
            if (i_txns.size() > 0) drive_i(i_txns[0]);
            else                   i_req = 1'b0;
         end
         if (d_ack && d_txns.size() > 0) begin
            void'(d_txns.pop_front());
            if (d_txns.size() > 0) drive_d(d_txns[0]);
            else                   d_req = 1'b0;
         end
      end
      if (i_txns.size() > 0 || d_txns.size() > 0) begin
         checks++;
         fails++;
         $display("[TB] FAIL %s timeout: %0d ops still pending, required 0", name,
                  i_txns.size() + d_txns.size());
         i_req = 1'b0;
         d_req = 1'b0;
         i_txns.delete();
         d_txns.delete();
         exp_order.delete();
         exp_i_data.delete();
         exp_d_data.delete();
      end
      if (single) checkOutput({name, " latency"}, 32'(cyc), 32'(lat_exp));
      checkOutput({name, " ram_wen pulses"}, 32'(wen_count - wen_start), 32'(wen_exp));
   endtask

   // Reset during a sub-word store: hit_cycle 2 lands in RDW, 3 in WR.
   task automatic resetAbort(input int hit_cycle, input string name);
      preload(16'h0400, 32'h55555555);
      @(negedge clk);
      drive_d(mk_txn(1'b1, 2'b00, 1'b0, 16'h0400, 32'h000000AA));
      repeat (hit_cycle) @(negedge clk);
      if (hit_cycle == 3) checkOutput({name, " ram_wen in WR"}, 32'(ram_wen), 32'd1);
      rst   = 1'b1;
      d_req = 1'b0;
      model_last = 1'b0;
      #1;
      checkOutput({name, " ram_wen"}, 32'(ram_wen), 32'd0);
      checkOutput({name, " d_ack"},   32'(d_ack),   32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput({name, " no ack"}, 32'(d_ack), 32'd0);
      end
      d_txns.push_back(mk_txn(1'b0, 2'b10, 1'b0, 16'h0400, 32'h0));
      applyStimulus({name, " readback"});
   endtask

   // Monitor: pops one expectation per ack and compares.
   task automatic monitor();
      logic        o;
      logic [31:0] ei;
      logic [32:0] ed;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (ram_wen) wen_count++;
            if (i_ack) begin
               if (exp_order.size() == 0 || exp_i_data.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL unexpected i_ack: got 1, expected 0");
               end else begin
                  o  = exp_order.pop_front();
                  ei = exp_i_data.pop_front();
                  checkOutput("grant order (i_ack)", 32'(o), 32'd0);
                  checkOutput("i_rdata", i_rdata, ei);
               end
            end
            if (d_ack) begin
               if (exp_order.size() == 0 || exp_d_data.size() == 0) begin
                  checks++;
                  fails++;
                  $display("[TB] FAIL unexpected d_ack: got 1, expected 0");
               end else begin
                  o  = exp_order.pop_front();
                  ed = exp_d_data.pop_front();
                  checkOutput("grant order (d_ack)", 32'(o), 32'd1);
                  if (ed[32]) checkOutput("d_rdata", d_rdata, ed[31:0]);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; i_req = 1'b0; i_addr = 16'h0;
      d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_signed = 1'b0;
      d_addr = 16'h0; d_wdata = 32'h0;
      pl_en = 1'b0; pl_addr = 16'h0; pl_data = 32'h0;
      checks = 0; fails = 0; wen_count = 0; model_last = 1'b0;
      for (int k = 0; k < 65536; k++) ref_mem[k] = fill_byte(16'(k));
      fork
         monitor();
      join_none

      #1 rst = 1'b1;
      #2;
      checkOutput("reset ram_addr",  32'(ram_addr), 32'd0);
      checkOutput("reset ram_wdata", ram_wdata,     32'd0);
      checkOutput("reset ram_wen",   32'(ram_wen),  32'd0);
      checkOutput("reset i_ack",     32'(i_ack),    32'd0);
      checkOutput("reset d_ack",     32'(d_ack),    32'd0);
      checkOutput("reset i_rdata",   i_rdata,       32'd0);
      checkOutput("reset d_rdata",   d_rdata,       32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed accesses");
      preload(16'h0100, 32'h11223344);
      i_txns.push_back(mk_txn(1'b0, 2'b10, 1'b0, 16'h0100, 32'h0));
      applyStimulus("fetch");

      preload(16'h0200, 32'h000000F0);
      d_txns.push_back(mk_txn(1'b0, 2'b00, 1'b1, 16'h0200, 32'h0));
      applyStimulus("signed byte load");
      d_txns.push_back(mk_txn(1'b0, 2'b00, 1'b0, 16'h0200, 32'h0));
      applyStimulus("unsigned byte load");

      preload(16'h0300, 32'hAABBCCDD);
      d_txns.push_back(mk_txn(1'b1, 2'b01, 1'b0, 16'h0300, 32'h00001234));
      applyStimulus("half store");
      d_txns.push_back(mk_txn(1'b0, 2'b10, 1'b0, 16'h0300, 32'h0));
      applyStimulus("half store readback");

      d_txns.push_back(mk_txn(1'b1, 2'b10, 1'b0, 16'hFFFE, 32'hDEADBEEF));
      applyStimulus("wrap word store");
      checkOutput("wrap byte 0x0000", 32'(ram_mem[0]), 32'h000000AD);
      checkOutput("wrap byte 0x0001", 32'(ram_mem[1]), 32'h000000DE);
      d_txns.push_back(mk_txn(1'b0, 2'b10, 1'b0, 16'hFFFE, 32'h0));
      applyStimulus("wrap word load");

      $display("[TB] held contention from reset");
      doReset();
      for (int k = 0; k < 3; k++) begin
         i_txns.push_back(mk_txn(1'b0, 2'b10, 1'b0, 16'(16'h0100 + 4*k), 32'h0));
         d_txns.push_back(mk_txn(1'b0, 2'(k), 1'b1, 16'(16'h0200 + 16'h0100*k), 32'h0));
      end
      applyStimulus("held contention");

      $display("[TB] reset abort");
      resetAbort(2, "abort in RDW");
      resetAbort(3, "abort in WR");

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) begin
         int ni = $urandom_range(0, 2);
         int nd = $urandom_range(0, 2);
         if (ni == 0 && nd == 0) nd = 1;
         for (int k = 0; k < ni; k++) i_txns.push_back(rand_txn(1'b0));
         for (int k = 0; k < nd; k++) d_txns.push_back(rand_txn(1'b1));
         applyStimulus("random");
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard drained", 32'(exp_order.size() + exp_i_data.size() + exp_d_data.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
